// File: rtl/spike_event_packer.sv
// -----------------------------------------------------------------------------
// spike_event_packer
//
// Packs per-sample spike detector flags into timestamped event words and
// buffers them in a first-word-fall-through FIFO for a downstream consumer.
//
// A free-running sample counter (ts) advances once per qualified sample.
// Any sample with at least one effective flag produces one event word
// {neo, ado, aso, ed, ts} that is written into the FIFO on the same edge.
//
// Optional feature (macro SPIKE_REFRACTORY_EN): each detector gets an 8-bit
// refractory counter; once a flag is accepted the detector is masked for the
// next REFRACT samples.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   sample_valid  in   qualifies one detector output sample
//   spike_neo     in   NEO detector flag   (event bit TS_WIDTH+3)
//   spike_ado     in   ADO detector flag   (event bit TS_WIDTH+2)
//   spike_aso     in   ASO detector flag   (event bit TS_WIDTH+1)
//   spike_ed      in   ED detector flag    (event bit TS_WIDTH+0)
//   ev_valid      out  event word available (FIFO non-empty)
//   ev_ready      in   consumer accepts the event word
//   ev_data       out  {neo, ado, aso, ed, timestamp}, head of FIFO
//   fifo_count    out  current FIFO occupancy
//   overflow      out  sticky: an event was dropped because the FIFO was full
//
// Handshake: a word transfers on a rising edge where ev_valid=1 and
// ev_ready=1. While ev_valid=1 and ev_ready=0, ev_data is held stable.
// ev_ready is ignored while the FIFO is empty. ev_data is don't-care when
// ev_valid=0.
// -----------------------------------------------------------------------------
module spike_event_packer #(
    parameter int TS_WIDTH   = 28,
    parameter int FIFO_DEPTH = 16,
    parameter int REFRACT    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_valid,
    input  logic                          spike_neo,
    input  logic                          spike_ado,
    input  logic                          spike_aso,
    input  logic                          spike_ed,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [TS_WIDTH+3:0]           ev_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = TS_WIDTH + 4;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

    logic [DW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;
    logic [TS_WIDTH-1:0] r_ts;
    logic                r_overflow;

    logic [3:0]          w_raw;
    logic [3:0]          w_mask;
    logic [3:0]          w_eff;
    logic                w_event;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    // Flag order matches the event word: neo in bit 3 down to ed in bit 0.
    assign w_raw = {spike_neo, spike_ado, spike_aso, spike_ed} & {4{sample_valid}};

`ifdef SPIKE_REFRACTORY_EN
    localparam logic [7:0] REFRACT_L = 8'(REFRACT);

    logic [7:0] r_refr [4];

    always_comb begin
        w_mask = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            w_mask[k] = (r_refr[k] != 8'd0);
        end
    end

    // Counters only move on qualified samples. Loading happens on flag
    // acceptance regardless of whether the FIFO could take the event, so a
    // dropped event still starts the refractory window.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_refr[k] <= 8'd0;
            end
        end else if (sample_valid) begin
            for (int k = 0; k < 4; k++) begin
                if (w_eff[k]) begin
                    r_refr[k] <= REFRACT_L;
                end else if (r_refr[k] != 8'd0) begin
                    r_refr[k] <= r_refr[k] - 8'd1;
                end
            end
        end
    end
`else
    assign w_mask = 4'b0000;
`endif

    assign w_eff   = w_raw & ~w_mask;
    assign w_event = |w_eff;

    assign w_full  = (r_count == DEPTH_L);
    assign w_empty = (r_count == '0);
    assign w_pop   = ev_ready && !w_empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

    // Timestamp counter: wraps silently at 2^TS_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= '0;
        end else if (sample_valid) begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Storage array carries no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_eff, r_ts};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign ev_valid   = !w_empty;
    assign ev_data    = r_mem[r_rd_ptr];
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_spike_event_packer.sv
// -----------------------------------------------------------------------------
// tb_spike_event_packer
//
// Directed bench for spike_event_packer. Two instances share the sample
// inputs: the main one (TS_WIDTH=28, FIFO_DEPTH=16) and a narrow one
// (TS_WIDTH=4, always ready) that exercises timestamp wrap. Expected words
// are queued by the driver and popped by negedge monitors on each transfer.
// -----------------------------------------------------------------------------
module tb_spike_event_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic        spike_neo, spike_ado, spike_aso, spike_ed;
    logic        ev_valid;
    logic        ev_ready;
    logic [31:0] ev_data;
    logic [4:0]  fifo_count;
    logic        overflow;

    logic        ev_valid4;
    logic        ev_ready4;
    logic [7:0]  ev_data4;
    logic [4:0]  fifo_count4;
    logic        overflow4;

    logic [31:0] exp_q[$];
    logic [7:0]  exp4_q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [27:0] m_ts;
    int          m_refr[4];

    always #5 clk = ~clk;

    assign ev_ready4 = 1'b1;

    spike_event_packer #(.TS_WIDTH(28), .FIFO_DEPTH(16), .REFRACT(8)) u_dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .spike_neo(spike_neo), .spike_ado(spike_ado),
        .spike_aso(spike_aso), .spike_ed(spike_ed),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    spike_event_packer #(.TS_WIDTH(4), .FIFO_DEPTH(16), .REFRACT(8)) u_dut4 (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .spike_neo(spike_neo), .spike_ado(spike_ado),
        .spike_aso(spike_aso), .spike_ed(spike_ed),
        .ev_valid(ev_valid4), .ev_ready(ev_ready4), .ev_data(ev_data4),
        .fifo_count(fifo_count4), .overflow(overflow4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        {spike_neo, spike_ado, spike_aso, spike_ed} = 4'b0000;
        exp_q.delete();
        exp4_q.delete();
        tick();
        tick();
        rst = 1'b0;
        m_ts = '0;
        for (int k = 0; k < 4; k++) m_refr[k] = 0;
    endtask

    // One qualified sample. 'fits' says whether the main FIFO has room by
    // hand analysis of the directed sequence; the narrow DUT never fills.
    task automatic sample(input logic [3:0] f, input bit fits);
        logic [3:0] eff;
        eff = f;
`ifdef SPIKE_REFRACTORY_EN
        for (int k = 0; k < 4; k++) begin
            if (m_refr[k] != 0) begin
                eff[k] = 1'b0;
                m_refr[k] = m_refr[k] - 1;
            end else if (f[k]) begin
                m_refr[k] = 8;
            end
        end
`endif
        sample_valid = 1'b1;
        {spike_neo, spike_ado, spike_aso, spike_ed} = f;
        if (eff != 4'b0000) begin
            if (fits) exp_q.push_back({eff, m_ts});
            exp4_q.push_back({eff, m_ts[3:0]});
        end
        tick();
        m_ts = m_ts + 1'b1;
        sample_valid = 1'b0;
        {spike_neo, spike_ado, spike_aso, spike_ed} = 4'b0000;
    endtask

    // Monitors: compare every transfer against the head of its queue.
    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL main_unexpected: got 0x%0h expected none at %0t", ev_data, $time);
            end else begin
                check("main_event", ev_data, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ev_valid4 && ev_ready4) begin
            if (exp4_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL ts4_unexpected: got 0x%0h expected none at %0t", ev_data4, $time);
            end else begin
                check("ts4_event", {24'd0, ev_data4}, {24'd0, exp4_q.pop_front()});
            end
        end
    end

    initial begin
        ev_ready = 1'b0;
        do_reset();

        // Reset state
        check("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
        check("rst_fifo_count", {27'd0, fifo_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);

        // Single neo event at ts=5, visible one cycle after the write
        ev_ready = 1'b1;
        for (int i = 0; i < 5; i++) sample(4'b0000, 1'b1);
        sample(4'b1000, 1'b1);
        check("lat_valid_after_write", {31'd0, ev_valid}, 32'd1);
        tick();
        check("lat_valid_one_cycle", {31'd0, ev_valid}, 32'd0);

        // Coincident ado+ed at ts=10 -> one event, flags 0101
        for (int i = 0; i < 4; i++) sample(4'b0000, 1'b1);
        sample(4'b0101, 1'b1);
        // Flags without sample_valid are ignored
        {spike_neo, spike_ado, spike_aso, spike_ed} = 4'b1111;
        tick();
        tick();
        {spike_neo, spike_ado, spike_aso, spike_ed} = 4'b0000;
        check("no_event_without_valid", {31'd0, ev_valid}, 32'd0);

        // Fill with ready low: 16 accepted, 17th dropped
        ev_ready = 1'b0;
        for (int i = 0; i < 17; i++) sample(4'b1111, (i < 16));
`ifndef SPIKE_REFRACTORY_EN
        check("full_count", {27'd0, fifo_count}, 32'd16);
        check("full_overflow", {31'd0, overflow}, 32'd1);
`endif
        // Full with a pop on the same edge: write accepted, count unchanged
        ev_ready = 1'b1;
        sample(4'b0011, 1'b1);
`ifndef SPIKE_REFRACTORY_EN
        check("full_push_pop_count", {27'd0, fifo_count}, 32'd16);
`endif
        for (int i = 0; i < 20; i++) tick();
        check("drained_count", {27'd0, fifo_count}, 32'd0);
`ifndef SPIKE_REFRACTORY_EN
        check("overflow_sticky", {31'd0, overflow}, 32'd1);
`endif

        // Neo held for 20 samples from ts=0
        do_reset();
        check("rst_clears_overflow", {31'd0, overflow}, 32'd0);
        ev_ready = 1'b1;
        for (int i = 0; i < 20; i++) sample(4'b1000, 1'b1);
        for (int i = 0; i < 5; i++) tick();

        // Reset with three words pending
        do_reset();
        ev_ready = 1'b0;
        sample(4'b1000, 1'b1);
        sample(4'b0100, 1'b1);
        sample(4'b0010, 1'b1);
        check("pending_count", {27'd0, fifo_count}, 32'd3);
        check("pending_valid", {31'd0, ev_valid}, 32'd1);
        rst = 1'b1;
        sample_valid = 1'b1;
        {spike_neo, spike_ado, spike_aso, spike_ed} = 4'b1111;
        ev_ready = 1'b1;
        exp_q.delete();
        exp4_q.delete();
        tick();
        check("midrst_valid", {31'd0, ev_valid}, 32'd0);
        check("midrst_count", {27'd0, fifo_count}, 32'd0);
        check("midrst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        sample_valid = 1'b0;
        {spike_neo, spike_ado, spike_aso, spike_ed} = 4'b0000;
        m_ts = '0;
        for (int k = 0; k < 4; k++) m_refr[k] = 0;
        sample(4'b0001, 1'b1);
        check("post_rst_valid", {31'd0, ev_valid}, 32'd1);

        // Bounded drain, then every expected word must have been seen
        for (int i = 0; i < 50 && (exp_q.size() != 0 || exp4_q.size() != 0); i++) tick();
        tick();
        check("main_queue_empty", exp_q.size(), 32'd0);
        check("ts4_queue_empty", exp4_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spike_event_packer.md
SPIKE_EVENT_PACKER -- requirements
Module: spike_event_packer

Interface
REQ-001 Parameter TS_WIDTH, default 28: timestamp width in bits.
REQ-002 Parameter FIFO_DEPTH, default 16: event FIFO entries; power of two, at least 2.
REQ-003 Parameter REFRACT, default 8: refractory length in samples, 1..255.
REQ-004 clk  input  1: single clock; all logic rising-edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 sample_valid  input  1: qualifies one detector output sample per assertion.
REQ-007 spike_neo, spike_ado, spike_aso, spike_ed  input  1 each: detector flags, sampled only when sample_valid=1.
REQ-008 ev_valid  output  1: event word available.
REQ-009 ev_ready  input  1: consumer accepts the event word.
REQ-010 ev_data  output  TS_WIDTH+4: {neo, ado, aso, ed, timestamp}; flags in MSBs, neo highest.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-012 overflow  output  1: sticky flag; an event was dropped.

Function
REQ-013 Timestamp counter ts increments by 1 (mod 2^TS_WIDTH) on each cycle with sample_valid=1; ts is not advanced otherwise.
REQ-014 Event timestamp = ts before increment; the first sample after reset is timestamp 0; 2^TS_WIDTH-1 wraps to 0 with no marker.
REQ-015 Effective flag = input flag AND sample_valid AND not masked (REQ-026); an event is generated only when at least one effective flag is 1.
REQ-016 The event word carries all effective flags of that sample; coincident detections produce one event, not several.
REQ-017 A generated event is written into the FIFO at the same clock edge at which sample_valid is sampled.
REQ-018 Latency: when the FIFO is empty, ev_valid=1 on the cycle after the write edge; there is no combinational bypass.
REQ-019 Handshake: a word transfers on an edge where ev_valid=1 and ev_ready=1; ev_data is held stable while ev_valid=1 and ev_ready=0.
REQ-020 ev_valid equals FIFO non-empty; ev_data is the head entry (first-word-fall-through); ev_data is don't-care when ev_valid=0.
REQ-021 Full FIFO with a pop on the same edge: the write is accepted and the count is unchanged.
REQ-022 Full FIFO with no pop: the event is dropped, overflow is set to 1, and ts still advances.
REQ-023 Empty FIFO: ev_ready is ignored; the count never underflows.
REQ-024 A simultaneous write and pop on a non-full, non-empty FIFO leaves fifo_count unchanged.

Reset
REQ-025 On rst=1 at an edge: ts=0, FIFO is emptied, ev_valid=0, fifo_count=0, overflow=0, all refractory counters=0; this applies mid-transfer and discards pending words; inputs during reset are ignored.

Configuration
REQ-026 Macro SPIKE_REFRACTORY_EN defined: each detector has its own 8-bit refractory counter; an accepted flag loads REFRACT; while nonzero, that flag is masked and the counter decrements on each sample_valid.
REQ-027 With SPIKE_REFRACTORY_EN defined: the counter loads on flag acceptance even when the event is dropped by REQ-022.
REQ-028 With SPIKE_REFRACTORY_EN defined: a detector is masked for exactly REFRACT samples after its accepted flag.
REQ-029 Macro SPIKE_REFRACTORY_EN undefined: no refractory counters exist, every asserted flag is effective, and REFRACT is unused.

Verification
REQ-030 Reset, then 5 samples with no flags, then spike_neo on the 6th sample with ev_ready=1 -> one event ev_data={1,0,0,0,ts=5}, ev_valid high for 1 cycle, starting 1 cycle after the write.
REQ-031 spike_ado and spike_ed on the same sample at ts=10 -> a single event with flags 0101 and timestamp 10.
REQ-032 ev_ready=0 and 17 spiking samples with FIFO_DEPTH=16 -> fifo_count=16 and overflow=1; draining returns 16 events in order, and overflow stays 1 until rst.
REQ-033 With SPIKE_REFRACTORY_EN and REFRACT=8, spike_neo held high for 20 samples starting at ts=0 -> events at ts 0, 9 and 18 only.
REQ-034 TS_WIDTH=4 and 17 consecutive spiking samples -> timestamps 0..15 then 0.
REQ-035 rst asserted while fifo_count=3 and ev_valid=1 -> next cycle ev_valid=0, fifo_count=0, and the next event has timestamp 0.
